rr_arbiter_12: RTL

- Round-robin arbiter that shares one resource among 12 requesters.
- Built around the 12-input priority-encode function (bit 0 = highest fixed priority, 4-bit index output).
- Holds a grant until the owner drops its request or a hold-time limit expires, then rotates priority past the last owner.
- Sits in front of any shared datapath unit (bus, ALU, memory port); downstream logic muxes on grant_idx.

---
 rtl/rr_arbiter_12_pkg.sv | 39 +++
 rtl/rr_arbiter_12_pick.sv | 37 +++
 rtl/rr_arbiter_12.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rr_arbiter_12_pkg.sv
// Shared constants, state encoding and index helpers for the 12-way round-robin arbiter.
package rr_arbiter_12_pkg;

    localparam int N     = 12;
    localparam int IDX_W = 4;

    localparam logic [IDX_W:0] N_WIDE = (IDX_W + 1)'(N);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Both operands are always in 0..N-1, so one conditional subtract wraps the sum.
    function automatic logic [IDX_W-1:0] add_mod_n(input logic [IDX_W-1:0] a,
                                                   input logic [IDX_W-1:0] b);
        logic [IDX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= N_WIDE) begin
            s = s - N_WIDE;
        end else begin
            s = s;
        end
        return s[IDX_W-1:0];
    endfunction

    function automatic logic [0:N-1] onehot_n(input logic [IDX_W-1:0] idx);
        logic [0:N-1] v;
        for (int i = 0; i < N; i++) begin
            if (IDX_W'(i) == idx) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter_12_pick.sv
// Combinational rotating priority pick: first requester at or after ptr, wrapping mod 12.
module rr_prior_pick
    import rr_arbiter_12_pkg::*;
(
    input  logic [0:N-1]     req,
    input  logic [0:IDX_W-1] ptr,
    output logic [0:IDX_W-1] idx,
    output logic             any
);

    logic [0:N-1]     rot_s;
    logic [IDX_W-1:0] enc_s;

    // Rotate so that rot_s[0] is the requester at ptr.
    always_comb begin
        rot_s = '0;
        for (int k = 0; k < N; k++) begin
            rot_s[k] = req[add_mod_n(ptr, IDX_W'(k))];
        end
    end

    // Fixed-priority encode, bit 0 highest; descending scan so the lowest hit wins.
    always_comb begin
        enc_s = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                enc_s = IDX_W'(k);
            end else begin
                enc_s = enc_s;
            end
        end
    end

    assign idx = add_mod_n(ptr, enc_s);
    assign any = |req;

endmodule

// File: rtl/rr_arbiter_12.sv
// Round-robin arbiter for 12 requesters with a per-owner hold limit and registered grant outputs.
module rr_arbiter_12
    import rr_arbiter_12_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:N-1]     req,
    output logic [0:N-1]     grant,
    output logic [0:IDX_W-1] grant_idx,
    output logic             grant_valid,
    output logic             expire
);

    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [0:N-1]     grant_q, grant_d;
    logic             expire_q, expire_d;

    logic [IDX_W-1:0] pick_ptr_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic             pick_any_s;
    logic             own_req_s;

    // While busy the pick is only consumed on release, when priority starts past the owner.
    assign pick_ptr_s = (state_q == ST_BUSY) ? add_mod_n(idx_q, IDX_W'(1)) : ptr_q;
    assign own_req_s  = req[idx_q];

    rr_prior_pick u_pick (
        .req (req),
        .ptr (pick_ptr_s),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    // Next-state logic: grant on idle, hold/count while busy, hand off on release.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        grant_d  = grant_q;
        expire_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hold_d = '0;
                if (pick_any_s) begin
                    state_d = ST_BUSY;
                    idx_d   = pick_idx_s;
                    valid_d = 1'b1;
                    grant_d = onehot_n(pick_idx_s);
                end else begin
                    idx_d   = '0;
                    valid_d = 1'b0;
                    grant_d = '0;
                end
            end
            ST_BUSY: begin
                if (own_req_s && (hold_q != HOLD_LAST)) begin
                    hold_d = hold_q + HOLD_W'(1);
                end else begin
                    ptr_d    = pick_ptr_s;
                    expire_d = own_req_s;
                    hold_d   = '0;
                    if (pick_any_s) begin
                        idx_d   = pick_idx_s;
                        valid_d = 1'b1;
                        grant_d = onehot_n(pick_idx_s);
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        valid_d = 1'b0;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
                hold_d  = '0;
                idx_d   = '0;
                valid_d = 1'b0;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            hold_q   <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            grant_q  <= '0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            grant_q  <= grant_d;
            expire_q <= expire_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;
    assign expire      = expire_q;

endmodule
